// File: rtl/ltc2324_axis_packer.sv
// ltc2324_axis_packer
// Buffers four-channel LTC2324-16 sample sets in a frame FIFO and streams each
// frame as two 32-bit AXI4-Stream beats, with tlast closing every PKT_FRAMES
// frames. Frames arriving while the FIFO is full are dropped and counted.
//
// Ports:
//   clk, rst          single clock, asynchronous active-high reset
//   capture_en        gate for incoming sample sets (ignored sets are not drops)
//   valid, ch1..ch4   one-cycle sample-set pulse and its four 16-bit samples
//   clr_status        synchronous clear of overflow / drop_cnt (a drop wins)
//   m_axis_*          AXI4-Stream master: tdata[31:0], tvalid, tready, tlast
//   overflow          sticky flag, set on any dropped frame
//   drop_cnt[15:0]    saturating dropped-frame count
module ltc2324_axis_packer #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned PKT_FRAMES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        capture_en,
    input  logic        valid,
    input  logic [15:0] ch1,
    input  logic [15:0] ch2,
    input  logic [15:0] ch3,
    input  logic [15:0] ch4,
    input  logic        clr_status,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        overflow,
    output logic [15:0] drop_cnt
);

    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned BEAT_W   = 2 * SAMPLE_W;
    localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W    = PTR_W + 1;
    localparam int unsigned CNT_W    = 16;

    localparam logic [OCC_W-1:0]    DEPTH_OCC  = OCC_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]    LAST_FRAME = CNT_W'(PKT_FRAMES - 1);
    localparam logic [SAMPLE_W-1:0] CNT_MAX    = '1;

    typedef struct packed {
        logic [SAMPLE_W-1:0] ch4;
        logic [SAMPLE_W-1:0] ch3;
        logic [SAMPLE_W-1:0] ch2;
        logic [SAMPLE_W-1:0] ch1;
    } frame_t;

    typedef enum logic {
        BEAT0 = 1'b0,
        BEAT1 = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    frame_t           mem [FIFO_DEPTH];
    frame_t           head;
    logic [OCC_W-1:0] wr_ptr;
    logic [OCC_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occ;
    logic [CNT_W-1:0] frm_cnt;
    logic             empty;
    logic             full;
    logic             wr_en;
    logic             drop;
    logic             pop;

    // Occupancy from the extra-bit pointers, taken at the start of the cycle.
    assign occ   = wr_ptr - rd_ptr;
    assign empty = (occ == '0);
    assign full  = (occ == DEPTH_OCC);
    assign wr_en = valid && capture_en && !full;
    assign drop  = valid && capture_en && full;
    assign head  = mem[rd_ptr[PTR_W-1:0]];

    // Frame storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[PTR_W-1:0]] <= frame_t'{ch4: ch4, ch3: ch3, ch2: ch2, ch1: ch1};
        end
    end

    // FIFO pointers and packet frame counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            frm_cnt <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + OCC_W'(1);
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + OCC_W'(1);
                frm_cnt <= m_axis_tlast ? '0 : frm_cnt + CNT_W'(1);
            end
        end
    end

    // Drop status; a drop in the same cycle as clr_status restarts the count at 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (clr_status) begin
                drop_cnt <= 16'd1;
            end else if (drop_cnt != CNT_MAX) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end else if (clr_status) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end
    end

    // Beat state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BEAT0;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            BEAT0: if (!empty && m_axis_tready) state_d = BEAT1;
            BEAT1: if (m_axis_tready)           state_d = BEAT0;
            default:                            state_d = BEAT0;
        endcase
    end

    // Stream outputs decode registered state only, so tvalid never follows tready.
    always_comb begin
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tlast  = 1'b0;
        pop           = 1'b0;
        case (state_q)
            BEAT0: begin
                m_axis_tvalid = !empty;
                if (!empty) begin
                    m_axis_tdata = BEAT_W'({head.ch2, head.ch1});
                end
            end
            BEAT1: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = BEAT_W'({head.ch4, head.ch3});
                m_axis_tlast  = (frm_cnt == LAST_FRAME);
                pop           = m_axis_tready;
            end
            default: begin
                m_axis_tvalid = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_ltc2324_axis_packer.sv
// Self-checking bench for ltc2324_axis_packer: randomized and directed sample
// sets feed a frame-level reference model; a negedge monitor compares every
// cycle's stream and status outputs against it.
module tb_ltc2324_axis_packer;

    localparam int DEPTH = 16;
    localparam int PKT   = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        capture_en = 1'b0;
    logic        valid = 1'b0;
    logic [15:0] ch1 = '0;
    logic [15:0] ch2 = '0;
    logic [15:0] ch3 = '0;
    logic [15:0] ch4 = '0;
    logic        clr_status = 1'b0;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic        m_axis_tlast;
    logic        overflow;
    logic [15:0] drop_cnt;

    ltc2324_axis_packer #(
        .FIFO_DEPTH (DEPTH),
        .PKT_FRAMES (PKT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .capture_en    (capture_en),
        .valid         (valid),
        .ch1           (ch1),
        .ch2           (ch2),
        .ch3           (ch3),
        .ch4           (ch4),
        .clr_status    (clr_status),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .overflow      (overflow),
        .drop_cnt      (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } beat_t;

    beat_t       exp_q[$];
    int unsigned frames_acc;
    logic        exp_ovf;
    int unsigned exp_drop;
    int          tests = 0;
    int          fails = 0;

    int          occ;
    logic        has;
    logic        mdrop;
    beat_t       b;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor and model: one step per cycle, mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
            check("rst_tlast", 64'(m_axis_tlast), 64'd0);
            check("rst_tdata", 64'(m_axis_tdata), 64'd0);
            check("rst_overflow", 64'(overflow), 64'd0);
            check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
            exp_q.delete();
            frames_acc = 0;
            exp_ovf    = 1'b0;
            exp_drop   = 0;
        end else begin
            check("overflow", 64'(overflow), 64'(exp_ovf));
            check("drop_cnt", 64'(drop_cnt), 64'(exp_drop));
            has = (exp_q.size() > 0);
            check("tvalid", 64'(m_axis_tvalid), 64'(has));
            if (has) begin
                check("tdata", 64'(m_axis_tdata), 64'(exp_q[0].data));
                check("tlast", 64'(m_axis_tlast), 64'(exp_q[0].last));
            end
            // Frames still held: a frame leaves only after its second beat.
            occ   = (exp_q.size() + 1) / 2;
            mdrop = valid && capture_en && (occ == DEPTH);
            if (has && m_axis_tready) begin
                void'(exp_q.pop_front());
            end
            if (valid && capture_en && !mdrop) begin
                b.data = {ch2, ch1};
                b.last = 1'b0;
                exp_q.push_back(b);
                b.data = {ch4, ch3};
                b.last = ((frames_acc % PKT) == (PKT - 1));
                exp_q.push_back(b);
                frames_acc++;
            end
            if (mdrop) begin
                exp_ovf  = 1'b1;
                exp_drop = clr_status ? 1 : ((exp_drop == 32'hFFFF) ? exp_drop : exp_drop + 1);
            end else if (clr_status) begin
                exp_ovf  = 1'b0;
                exp_drop = 0;
            end
        end
    end

    task automatic drive(input logic v, input logic en, input logic rdy, input logic clr,
                         input logic [63:0] d);
        @(posedge clk);
        #2;
        valid         = v;
        capture_en    = en;
        m_axis_tready = rdy;
        clr_status    = clr;
        {ch4, ch3, ch2, ch1} = d;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b1, rdy, 1'b0, {$urandom, $urandom});
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #2;
        rst   = 1'b1;
        valid = 1'b0;
        repeat (n) @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic incr_frames(input int n, input int base, input logic rdy);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, 1'b1, rdy, 1'b0,
                  {16'(4*(base+i)+3), 16'(4*(base+i)+2), 16'(4*(base+i)+1), 16'(4*(base+i))});
            idle(2, rdy);
        end
    endtask

    int p;

    initial begin
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;

        // Single frame with ready held high.
        drive(1'b1, 1'b1, 1'b1, 1'b0, 64'h4444_3333_2222_1111);
        idle(5, 1'b1);

        // Packetisation from a fresh reset; last two frames start a partial packet.
        do_reset(2);
        incr_frames(10, 0, 1'b1);
        idle(4, 1'b1);

        // Back-pressure hold for 20 cycles, then release.
        drive(1'b1, 1'b1, 1'b0, 1'b0, {$urandom, $urandom});
        drive(1'b1, 1'b1, 1'b0, 1'b0, {$urandom, $urandom});
        idle(20, 1'b0);
        idle(8, 1'b1);

        // Overflow: 20 pulses into a stalled stream, drain, then clear.
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, {$urandom, $urandom});
        idle(40, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 64'd0);
        idle(3, 1'b1);

        // Full FIFO: drop together with clr, then drop on the popping handshake.
        for (int i = 0; i < DEPTH; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, {$urandom, $urandom});
        drive(1'b1, 1'b1, 1'b0, 1'b1, {$urandom, $urandom});
        drive(1'b0, 1'b1, 1'b1, 1'b0, 64'd0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, {$urandom, $urandom});
        drive(1'b1, 1'b1, 1'b1, 1'b0, {$urandom, $urandom});
        idle(40, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 64'd0);

        // Capture disabled: pulses are neither stored nor dropped.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b0, {$urandom, $urandom});
            drive(1'b0, 1'b0, 1'b1, 1'b0, 64'd0);
        end
        idle(3, 1'b1);

        // Randomized traffic with segments of varying back-pressure.
        for (int s = 0; s < 30; s++) begin
            p = $urandom_range(0, 3);
            for (int i = 0; i < 100; i++) begin
                drive($urandom_range(0, 2) == 0, $urandom_range(0, 7) != 0,
                      $urandom_range(0, 3) >= p, $urandom_range(0, 63) == 0,
                      {$urandom, $urandom});
            end
        end
        idle(40, 1'b1);

        // Reset mid-packet, then a fresh packet must close after PKT frames.
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, {$urandom, $urandom});
        idle(3, 1'b1);
        do_reset(1);
        incr_frames(2 * PKT + 1, 100, 1'b1);
        idle(10, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard stop in case the stimulus never completes.
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got no end, expected end");
        $fatal(1);
    end

endmodule
